// File: rtl/uart_disp_pkg.sv
// Shared types and constants for the matrix-to-UART ASCII printer.
// Holds the frame FSM state encoding, ASCII byte values and dimension-width helper.
package uart_disp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CONV,
      ST_SEND_SIGN,
      ST_SEND_DIGIT,
      ST_SEND_SEP,
      ST_SEND_CR,
      ST_SEND_LF,
      ST_WAIT_TX,
      ST_DONE
   } disp_state_e;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // Width needed to hold a dimension value in the range 0..max_dim.
   function automatic int unsigned dim_width(input int unsigned max_dim);
      return $clog2(max_dim + 1);
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// A start pulse loads the input; done pulses once, DATA_W cycles later, and bcd holds until the next start.
module bin_to_bcd_seq #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0]   r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_run;
   logic                r_done;

   logic [4*DIGITS-1:0] w_adj;
   logic [4*DIGITS-1:0] w_bcd_sh;
   logic [DATA_W-1:0]   w_bin_sh;

   // Add-3 correction on every digit of 5 or more before the shift.
   for (genvar gd = 0; gd < DIGITS; gd++) begin : g_adj
      assign w_adj[4*gd +: 4] = (r_bcd[4*gd +: 4] >= 4'd5) ? (r_bcd[4*gd +: 4] + 4'd3)
                                                           : r_bcd[4*gd +: 4];
   end

   assign {w_bcd_sh, w_bin_sh} = {w_adj[4*DIGITS-2:0], r_bin, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
         end else if (r_run) begin
            r_bin <= w_bin_sh;
            r_bcd <= w_bcd_sh;
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: rtl/uart_matrix_printer.sv
// Prints a rows x cols sub-matrix as right-aligned decimal ASCII, one byte per UART handshake.
// The next element's BCD conversion starts on the last byte of the current one so it overlaps the wait.
module uart_matrix_printer
   import uart_disp_pkg::*;
#(
   parameter int unsigned MAX_DIM  = 5,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DIGITS   = 3,
   parameter logic [7:0]  SEP_CHAR = 8'h20,
   localparam int unsigned DIM_W   = dim_width(MAX_DIM)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              display_start,
   input  logic [DIM_W-1:0]                  rows,
   input  logic [DIM_W-1:0]                  cols,
   input  logic                              signed_mode,
   input  logic                              zero_pad,
   input  logic                              crlf,
   input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_flat,
   output logic [7:0]                        tx_data,
   output logic                              tx_start,
   input  logic                              tx_done,
   output logic                              tx_busy,
   output logic                              display_done,
   output logic                              dim_err
);

   localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   disp_state_e r_state, w_state_nxt;
   disp_state_e r_after, w_after_nxt;

   logic [DIM_W-1:0] r_rows, w_rows_nxt;
   logic [DIM_W-1:0] r_cols, w_cols_nxt;
   logic             r_signed, w_signed_nxt;
   logic             r_zpad, w_zpad_nxt;
   logic             r_crlf, w_crlf_nxt;
   logic [DIM_W-1:0] r_row, w_row_nxt;
   logic [DIM_W-1:0] r_col, w_col_nxt;
   logic [DIG_W-1:0] r_dig, w_dig_nxt;
   logic             r_lead, w_lead_nxt;
   logic             r_neg;
   logic             r_conv_rdy;
   logic [7:0]       r_tx_data, w_tx_data_nxt;
   logic             r_tx_start, w_tx_start_nxt;
   logic             r_tx_busy, w_tx_busy_nxt;
   logic             r_disp_done, w_disp_done_nxt;
   logic             r_dim_err, w_dim_err_nxt;

   logic [DATA_W-1:0]   w_elems [MAX_DIM][MAX_DIM];
   logic [DIM_W-1:0]    w_ld_row;
   logic [DIM_W-1:0]    w_ld_col;
   logic                w_ld_signed;
   logic [DATA_W-1:0]   w_raw;
   logic                w_neg;
   logic [DATA_W-1:0]   w_mag;
   logic                w_bcd_start;
   logic                w_bcd_done;
   logic [4*DIGITS-1:0] w_bcd;
   logic [3:0]          w_digits [DIGITS];
   logic [3:0]          w_digit;
   logic                w_last_dig;
   logic                w_last_col;
   logic                w_last_row;
   logic                w_dim_bad;

   for (genvar gr = 0; gr < MAX_DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < MAX_DIM; gc++) begin : g_col
         assign w_elems[gr][gc] = matrix_flat[(gr*MAX_DIM + gc)*DATA_W +: DATA_W];
      end
   end

   // Digit 0 of the array is the most significant printed digit.
   for (genvar gd = 0; gd < DIGITS; gd++) begin : g_dig
      assign w_digits[gd] = w_bcd[4*(DIGITS-1-gd) +: 4];
   end

   // Two's-complement negate; the most negative value yields its correct unsigned magnitude.
   assign w_raw = w_elems[w_ld_row][w_ld_col];
   assign w_neg = w_ld_signed & w_raw[DATA_W-1];
   assign w_mag = w_neg ? ((~w_raw) + DATA_W'(1)) : w_raw;

   assign w_digit    = w_digits[r_dig];
   assign w_last_dig = (r_dig == DIG_W'(DIGITS - 1));
   assign w_last_col = (r_col == r_cols - DIM_W'(1));
   assign w_last_row = (r_row == r_rows - DIM_W'(1));
   assign w_dim_bad  = (rows == '0) || (cols == '0) ||
                       (rows > DIM_W'(MAX_DIM)) || (cols > DIM_W'(MAX_DIM));

   bin_to_bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_bcd_start),
      .bin   (w_mag),
      .done  (w_bcd_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_after     <= ST_IDLE;
         r_rows      <= '0;
         r_cols      <= '0;
         r_signed    <= 1'b0;
         r_zpad      <= 1'b0;
         r_crlf      <= 1'b0;
         r_row       <= '0;
         r_col       <= '0;
         r_dig       <= '0;
         r_lead      <= 1'b0;
         r_neg       <= 1'b0;
         r_conv_rdy  <= 1'b0;
         r_tx_data   <= '0;
         r_tx_start  <= 1'b0;
         r_tx_busy   <= 1'b0;
         r_disp_done <= 1'b0;
         r_dim_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_after     <= w_after_nxt;
         r_rows      <= w_rows_nxt;
         r_cols      <= w_cols_nxt;
         r_signed    <= w_signed_nxt;
         r_zpad      <= w_zpad_nxt;
         r_crlf      <= w_crlf_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_dig       <= w_dig_nxt;
         r_lead      <= w_lead_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_tx_start  <= w_tx_start_nxt;
         r_tx_busy   <= w_tx_busy_nxt;
         r_disp_done <= w_disp_done_nxt;
         r_dim_err   <= w_dim_err_nxt;
         // The conversion may finish while a byte is still in flight; remember it for CONV.
         if (w_bcd_start) begin
            r_neg      <= w_neg;
            r_conv_rdy <= 1'b0;
         end else if (w_bcd_done) begin
            r_conv_rdy <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_after_nxt     = r_after;
      w_rows_nxt      = r_rows;
      w_cols_nxt      = r_cols;
      w_signed_nxt    = r_signed;
      w_zpad_nxt      = r_zpad;
      w_crlf_nxt      = r_crlf;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_dig_nxt       = r_dig;
      w_lead_nxt      = r_lead;
      w_tx_data_nxt   = r_tx_data;
      w_tx_start_nxt  = 1'b0;
      w_tx_busy_nxt   = r_tx_busy;
      w_disp_done_nxt = 1'b0;
      w_dim_err_nxt   = 1'b0;
      w_bcd_start     = 1'b0;
      w_ld_row        = r_row;
      w_ld_col        = r_col;
      w_ld_signed     = r_signed;

      case (r_state)
         ST_IDLE: begin
            if (display_start) begin
               w_rows_nxt   = rows;
               w_cols_nxt   = cols;
               w_signed_nxt = signed_mode;
               w_zpad_nxt   = zero_pad;
               w_crlf_nxt   = crlf;
               if (w_dim_bad) begin
                  w_dim_err_nxt   = 1'b1;
                  w_disp_done_nxt = 1'b1;
               end else begin
                  w_ld_row      = '0;
                  w_ld_col      = '0;
                  w_ld_signed   = signed_mode;
                  w_bcd_start   = 1'b1;
                  w_row_nxt     = '0;
                  w_col_nxt     = '0;
                  w_tx_busy_nxt = 1'b1;
                  w_state_nxt   = ST_CONV;
               end
            end
         end
         ST_CONV: begin
            if (w_bcd_done || r_conv_rdy) begin
               w_dig_nxt   = '0;
               w_lead_nxt  = 1'b1;
               w_state_nxt = r_signed ? ST_SEND_SIGN : ST_SEND_DIGIT;
            end
         end
         ST_SEND_SIGN: begin
            w_tx_data_nxt  = r_neg ? ASCII_MINUS : ASCII_SPACE;
            w_tx_start_nxt = 1'b1;
            w_after_nxt    = ST_SEND_DIGIT;
            w_state_nxt    = ST_WAIT_TX;
         end
         ST_SEND_DIGIT: begin
            if ((w_digit == 4'd0) && r_lead && !r_zpad && !w_last_dig) begin
               w_tx_data_nxt = ASCII_SPACE;
            end else begin
               w_tx_data_nxt = ASCII_ZERO | {4'h0, w_digit};
               w_lead_nxt    = 1'b0;
            end
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = ST_WAIT_TX;
            if (!w_last_dig) begin
               w_dig_nxt   = r_dig + DIG_W'(1);
               w_after_nxt = ST_SEND_DIGIT;
            end else if (!w_last_col) begin
               w_after_nxt = ST_SEND_SEP;
            end else if (r_crlf) begin
               w_after_nxt = ST_SEND_CR;
            end else begin
               w_after_nxt = ST_SEND_LF;
            end
         end
         ST_SEND_SEP: begin
            w_tx_data_nxt  = SEP_CHAR;
            w_tx_start_nxt = 1'b1;
            w_ld_col       = r_col + DIM_W'(1);
            w_bcd_start    = 1'b1;
            w_col_nxt      = w_ld_col;
            w_after_nxt    = ST_CONV;
            w_state_nxt    = ST_WAIT_TX;
         end
         ST_SEND_CR: begin
            w_tx_data_nxt  = ASCII_CR;
            w_tx_start_nxt = 1'b1;
            w_after_nxt    = ST_SEND_LF;
            w_state_nxt    = ST_WAIT_TX;
         end
         ST_SEND_LF: begin
            w_tx_data_nxt  = ASCII_LF;
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = ST_WAIT_TX;
            if (w_last_row) begin
               w_after_nxt = ST_DONE;
            end else begin
               w_ld_row    = r_row + DIM_W'(1);
               w_ld_col    = '0;
               w_bcd_start = 1'b1;
               w_row_nxt   = w_ld_row;
               w_col_nxt   = '0;
               w_after_nxt = ST_CONV;
            end
         end
         ST_WAIT_TX: begin
            if (tx_done) begin
               w_state_nxt = r_after;
               if (r_after == ST_DONE) begin
                  w_disp_done_nxt = 1'b1;
                  w_tx_busy_nxt   = 1'b0;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign tx_data      = r_tx_data;
   assign tx_start     = r_tx_start;
   assign tx_busy      = r_tx_busy;
   assign display_done = r_disp_done;
   assign dim_err      = r_dim_err;

endmodule

// File: tb/tb_uart_matrix_printer.sv
// Directed bench for uart_matrix_printer: drives frames through a modelled transmitter and checks
// the byte stream, handshake protocol, timing and error pulses against hand-written expectations.
module tb_uart_matrix_printer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         display_start;
   logic [2:0]   rows;
   logic [2:0]   cols;
   logic         signed_mode;
   logic         zero_pad;
   logic         crlf;
   logic [199:0] matrix_flat;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         tx_done;
   logic         tx_busy;
   logic         display_done;
   logic         dim_err;

   always #5 clk = ~clk;

   uart_matrix_printer #(
      .MAX_DIM  (5),
      .DATA_W   (8),
      .DIGITS   (3),
      .SEP_CHAR (8'h20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .display_start (display_start),
      .rows          (rows),
      .cols          (cols),
      .signed_mode   (signed_mode),
      .zero_pad      (zero_pad),
      .crlf          (crlf),
      .matrix_flat   (matrix_flat),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .tx_done       (tx_done),
      .tx_busy       (tx_busy),
      .display_done  (display_done),
      .dim_err       (dim_err)
   );

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   logic [7:0]  q_bytes[$];
   int unsigned n_dd, n_de, n_viol, first_lat, max_gap, dd_cyc, de_cyc;
   bit          timed_out, busy_after_start, busy_ever;

   task automatic set_elem(input int unsigned r, input int unsigned c, input logic [7:0] v);
      matrix_flat[(r*5 + c)*8 +: 8] = v;
   endtask

   task automatic cfg(input int unsigned r, input int unsigned c, input bit sm, input bit zp, input bit cr);
      rows        = 3'(r);
      cols        = 3'(c);
      signed_mode = sm;
      zero_pad    = zp;
      crlf        = cr;
   endtask

   // Locate the first byte where the captured stream differs from exp (-1 when identical).
   task automatic diff_bytes(input string exp, output int idx, output logic [7:0] got, output logic [7:0] want);
      int n;
      idx  = -1;
      got  = 'x;
      want = 'x;
      n = (exp.len() > q_bytes.size()) ? exp.len() : q_bytes.size();
      for (int i = 0; i < n; i++) begin
         if (idx == -1) begin
            if (i >= q_bytes.size() || i >= exp.len() || q_bytes[i] !== exp[i]) begin
               idx = i;
               if (i < q_bytes.size()) got = q_bytes[i];
               if (i < exp.len()) want = exp[i];
            end
         end
      end
   endtask

   // Pulse display_start, then act as the transmitter until display_done plus a tail, or stop_after bytes.
   task automatic run_frame(input int unsigned max_delay, input bit inject,
                            input int unsigned stop_after, input int unsigned tail);
      bit          pending, seen_dd, finished;
      int unsigned cnt, last_done, tail_left;
      logic [7:0]  held;
      q_bytes.delete();
      n_dd = 0; n_de = 0; n_viol = 0; first_lat = 0; max_gap = 0; dd_cyc = 0; de_cyc = 0;
      timed_out = 1'b0; busy_ever = 1'b0;
      pending = 1'b0; seen_dd = 1'b0; finished = 1'b0;
      cnt = 0; last_done = 0; tail_left = tail; held = '0;
      display_start = 1'b1;
      @(posedge clk); #1;
      display_start = 1'b0;
      busy_after_start = tx_busy;
      for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
         tx_done = 1'b0;
         if (tx_busy) busy_ever = 1'b1;
         if (tx_start) begin
            if (pending) n_viol++;
            if (q_bytes.size() == 0) first_lat = cyc;
            else if (cyc - last_done > max_gap) max_gap = cyc - last_done;
            q_bytes.push_back(tx_data);
            held    = tx_data;
            pending = 1'b1;
            cnt     = $urandom_range(max_delay, 1);
         end else if (pending) begin
            if (tx_data !== held) n_viol++;
            cnt--;
            if (cnt == 0) begin
               tx_done   = 1'b1;
               pending   = 1'b0;
               last_done = cyc;
            end
         end
         if (display_done) begin
            n_dd++;
            dd_cyc  = cyc;
            seen_dd = 1'b1;
            if (tx_busy !== 1'b0) n_viol++;
            if (q_bytes.size() != 0 && cyc != last_done + 1) n_viol++;
         end
         if (dim_err) begin
            n_de++;
            de_cyc = cyc;
         end
         display_start = inject && tx_busy && ($urandom_range(3, 0) == 0);
         if (stop_after != 0 && q_bytes.size() == stop_after) begin
            finished = 1'b1;
            break;
         end
         if (seen_dd) begin
            if (tail_left == 0) begin
               finished = 1'b1;
               break;
            end
            tail_left--;
         end
         @(posedge clk); #1;
      end
      timed_out     = !finished;
      display_start = 1'b0;
      tx_done       = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; display_start = 1'b0; tx_done = 1'b0;
      cfg(1, 1, 0, 0, 0);
      matrix_flat = '0;
      #3;
      n_vec++;
      if ({tx_data, tx_start, tx_busy, display_done, dim_err} !== 12'h000) begin
         n_miss++;
         $display("FAIL reset_outputs: got %h want 000", {tx_data, tx_start, tx_busy, display_done, dim_err});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({tx_data, tx_start, tx_busy, display_done, dim_err} !== 12'h000) begin
         n_miss++;
         $display("FAIL idle_after_reset: got %h want 000", {tx_data, tx_start, tx_busy, display_done, dim_err});
      end
   endtask

   task automatic load_2x3;
      matrix_flat = {25{8'hAA}};
      set_elem(0, 0, 8'd1);  set_elem(0, 1, 8'd23); set_elem(0, 2, 8'd255);
      set_elem(1, 0, 8'd0);  set_elem(1, 1, 8'd7);  set_elem(1, 2, 8'd100);
   endtask

   // Common frame checks shared by the printable-frame scenarios, each with its own label.
   task automatic check_frame(input string name, input string exp);
      int         idx;
      logic [7:0] got, want;
      n_vec++;
      if (timed_out !== 1'b0) begin
         n_miss++; $display("FAIL %s timeout: got %0d want 0", name, timed_out);
      end
      n_vec++;
      if (q_bytes.size() != exp.len()) begin
         n_miss++; $display("FAIL %s byte_count: got %0d want %0d", name, q_bytes.size(), exp.len());
      end
      diff_bytes(exp, idx, got, want);
      n_vec++;
      if (idx != -1) begin
         n_miss++; $display("FAIL %s text: byte %0d got %h want %h", name, idx, got, want);
      end
      n_vec++;
      if (n_dd != 1 || n_de != 0) begin
         n_miss++; $display("FAIL %s done_err_pulses: got %0d/%0d want 1/0", name, n_dd, n_de);
      end
      n_vec++;
      if (n_viol != 0) begin
         n_miss++; $display("FAIL %s protocol: got %0d violations want 0", name, n_viol);
      end
      n_vec++;
      if (busy_after_start !== 1'b1 || tx_busy !== 1'b0) begin
         n_miss++; $display("FAIL %s busy: got rise=%0d end=%0d want 1/0", name, busy_after_start, tx_busy);
      end
      n_vec++;
      if (first_lat > 12 || max_gap > 12) begin
         n_miss++; $display("FAIL %s latency: got first=%0d gap=%0d want <=12", name, first_lat, max_gap);
      end
   endtask

   task automatic test_unsigned_2x3;
      load_2x3();
      cfg(2, 3, 0, 0, 0);
      run_frame(1, 1'b0, 0, 20);
      check_frame("unsigned_2x3", "  1  23 255\n  0   7 100\n");
   endtask

   task automatic test_signed_crlf;
      matrix_flat = {25{8'h55}};
      set_elem(0, 0, 8'h80); set_elem(0, 1, 8'd5);
      cfg(1, 2, 1, 0, 1);
      run_frame(2, 1'b0, 0, 20);
      check_frame("signed_crlf", "-128    5\r\n");
   endtask

   task automatic test_signed_zero_pad;
      matrix_flat = {25{8'h55}};
      set_elem(0, 0, 8'hFF); set_elem(0, 1, 8'h7F);
      cfg(1, 2, 1, 1, 0);
      run_frame(3, 1'b0, 0, 20);
      check_frame("signed_zero_pad", "-001  127\n");
   endtask

   task automatic test_zero_pad;
      matrix_flat = {25{8'h33}};
      set_elem(0, 0, 8'd7);
      cfg(1, 1, 0, 1, 0);
      run_frame(1, 1'b0, 0, 20);
      check_frame("zero_pad_1x1", "007\n");
   endtask

   task automatic test_max_dim;
      string exp;
      exp = "";
      for (int unsigned r = 0; r < 5; r++) begin
         for (int unsigned c = 0; c < 5; c++) begin
            set_elem(r, c, 8'(r*10 + c));
            exp = {exp, $sformatf("%3d", r*10 + c), (c == 4) ? "\r\n" : " "};
         end
      end
      cfg(5, 5, 0, 0, 1);
      run_frame(1, 1'b0, 0, 20);
      check_frame("max_dim_5x5", exp);
   endtask

   task automatic test_dim_err;
      int unsigned vr [4] = '{0, 2, 0, 6};
      int unsigned vc [4] = '{3, 6, 0, 1};
      for (int k = 0; k < 4; k++) begin
         cfg(vr[k], vc[k], 0, 0, 0);
         run_frame(1, 1'b0, 0, 20);
         n_vec++;
         if (n_de != 1 || n_dd != 1 || de_cyc != dd_cyc || de_cyc != 0 || timed_out) begin
            n_miss++;
            $display("FAIL dim_err_%0dx%0d pulses: got err=%0d@%0d done=%0d@%0d want 1@0 1@0",
                     vr[k], vc[k], n_de, de_cyc, n_dd, dd_cyc);
         end
         n_vec++;
         if (q_bytes.size() != 0 || busy_ever) begin
            n_miss++;
            $display("FAIL dim_err_%0dx%0d quiet: got bytes=%0d busy=%0d want 0/0",
                     vr[k], vc[k], q_bytes.size(), busy_ever);
         end
      end
   endtask

   task automatic test_back_to_back;
      load_2x3();
      cfg(2, 3, 0, 0, 0);
      run_frame(50, 1'b1, 0, 40);
      check_frame("random_delay_inject", "  1  23 255\n  0   7 100\n");
      run_frame(7, 1'b1, 0, 40);
      check_frame("back_to_back", "  1  23 255\n  0   7 100\n");
   endtask

   task automatic test_reset_mid;
      load_2x3();
      cfg(2, 3, 0, 0, 0);
      run_frame(4, 1'b0, 5, 0);
      n_vec++;
      if (q_bytes.size() != 5 || timed_out) begin
         n_miss++; $display("FAIL mid_reset_progress: got %0d bytes want 5", q_bytes.size());
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({tx_data, tx_start, tx_busy, display_done, dim_err} !== 12'h000) begin
         n_miss++;
         $display("FAIL mid_reset_outputs: got %h want 000", {tx_data, tx_start, tx_busy, display_done, dim_err});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         n_vec++;
         if (display_done !== 1'b0 || tx_busy !== 1'b0) begin
            n_miss++; $display("FAIL mid_reset_quiet: got done=%0d busy=%0d want 0/0", display_done, tx_busy);
         end
      end
      run_frame(3, 1'b0, 0, 20);
      check_frame("after_mid_reset", "  1  23 255\n  0   7 100\n");
   endtask

   initial begin
      test_reset();
      test_unsigned_2x3();
      test_signed_crlf();
      test_signed_zero_pad();
      test_zero_pad();
      test_max_dim();
      test_dim_err();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
